// File: rtl/int_muldiv_pkg.sv
// Shared encodings for the iterative integer multiply/divide unit:
// operation codes, FSM state codes and operand-signedness helpers.
package int_muldiv_pkg;

  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic op_is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU) || (op == MD_REM) || (op == MD_REMU);
  endfunction

  function automatic logic op_a_signed(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic op_b_signed(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/int_muldiv.sv
// Radix-2 iterative integer multiply/divide (RISC-V M-style op set).
// Optional MULDIV_FAST_MUL_EN: single-cycle combinational multiplier for multiply ops.
module int_muldiv
  import int_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);

  logic [1:0]         state;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   mag_a_q;
  logic [WIDTH-1:0]   mag_b_q;
  logic               neg_q;
  logic               neg_r;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_step;

  logic               a_neg, b_neg, is_div, div_zero, div_ovf;
  logic [WIDTH-1:0]   abs_a, abs_b, special_res;
  logic [WIDTH-1:0]   calc_res;

  assign ready = (state == ST_IDLE);
  assign done  = (state == ST_DONE);

  // Accept-time decode: operand magnitudes and the short-circuit divide cases
  always_comb begin
    is_div   = op_is_div(op);
    a_neg    = a[WIDTH-1] & op_a_signed(op);
    b_neg    = b[WIDTH-1] & op_b_signed(op);
    abs_a    = a_neg ? -a : a;
    abs_b    = b_neg ? -b : b;
    div_zero = is_div && (b == '0);
    div_ovf  = ((op == MD_DIV) || (op == MD_REM)) &&
               (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
    special_res = '0;
    if (div_zero) begin
      special_res = ((op == MD_DIV) || (op == MD_DIVU)) ? '1 : a;
    end else if (div_ovf) begin
      special_res = (op == MD_DIV) ? a : '0;
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;
  logic [2*WIDTH-1:0] fast_fix;
  logic [WIDTH-1:0]   fast_res;

  always_comb begin
    fast_prod = {{WIDTH{1'b0}}, abs_a} * {{WIDTH{1'b0}}, abs_b};
    fast_fix  = (a_neg ^ b_neg) ? -fast_prod : fast_prod;
    fast_res  = (op == MD_MUL) ? fast_fix[WIDTH-1:0] : fast_fix[2*WIDTH-1:WIDTH];
  end
`endif

  // One radix-2 step. acc holds {hi, lo}: for multiply hi is the running partial
  // product and lo the remaining multiplier bits; for divide hi is the partial
  // remainder and lo shifts dividend bits out and quotient bits in.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_sub;
  logic             ge;

  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mag_a_q : {WIDTH{1'b0}})};
    rem_sh   = acc[2*WIDTH-1:WIDTH-1];
    ge       = (rem_sh >= {1'b0, mag_b_q});
    rem_sub  = rem_sh[WIDTH-1:0] - mag_b_q;
    acc_step = '0;
    if (op_is_div(op_q)) begin
      acc_step = {(ge ? rem_sub : rem_sh[WIDTH-1:0]), acc[WIDTH-2:0], ge};
    end else begin
      acc_step = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  // Sign fix-up applied to the final step's value
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  always_comb begin
    prod_fix = neg_q ? -acc_step : acc_step;
    quo_fix  = neg_q ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
    rem_fix  = neg_r ? -acc_step[2*WIDTH-1:WIDTH] : acc_step[2*WIDTH-1:WIDTH];
    case (op_q)
      MD_MUL:                        calc_res = prod_fix[WIDTH-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU:  calc_res = prod_fix[2*WIDTH-1:WIDTH];
      MD_DIV, MD_DIVU:               calc_res = quo_fix;
      default:                       calc_res = rem_fix;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      op_q    <= '0;
      mag_a_q <= '0;
      mag_b_q <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      cnt     <= '0;
      acc     <= '0;
      result  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q    <= op;
            mag_a_q <= abs_a;
            mag_b_q <= abs_b;
            neg_q   <= a_neg ^ b_neg;
            neg_r   <= a_neg;
            cnt     <= CW'(WIDTH - 1);
            acc     <= is_div ? {{WIDTH{1'b0}}, abs_a} : {{WIDTH{1'b0}}, abs_b};
            if (div_zero || div_ovf) begin
              result <= special_res;
              state  <= ST_DONE;
            end
`ifdef MULDIV_FAST_MUL_EN
            else if (!is_div) begin
              result <= fast_res;
              state  <= ST_DONE;
            end
`endif
            else begin
              state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          acc <= acc_step;
          cnt <= cnt - CW'(1);
          if (cnt == '0) begin
            result <= calc_res;
            state  <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_int_muldiv.sv
// Scoreboard testbench for int_muldiv: expected result and latency are queued
// at issue time from a native-arithmetic reference and compared on done.
module tb_int_muldiv;
  import int_muldiv_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         ready, done;
  logic [W-1:0] result;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [W-1:0] res;
    int           lat;
    string        name;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  int_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .ready(ready), .done(done), .result(result)
  );

  function automatic exp_t ref_op(input logic [2:0] o, input logic [W-1:0] x,
                                  input logic [W-1:0] y, input string nm);
    logic signed [W-1:0] sx, sy;
    logic [2*W-1:0]      p;
    exp_t                e;
    sx = x;
    sy = y;
    e.name = nm;
    e.lat  = W + 1;
    e.res  = '0;
    case (o)
      MD_MUL:    begin p = {{W{1'b0}}, x} * {{W{1'b0}}, y};       e.res = p[W-1:0];   end
      MD_MULH:   begin p = {{W{x[W-1]}}, x} * {{W{y[W-1]}}, y};   e.res = p[2*W-1:W]; end
      MD_MULHSU: begin p = {{W{x[W-1]}}, x} * {{W{1'b0}}, y};     e.res = p[2*W-1:W]; end
      MD_MULHU:  begin p = {{W{1'b0}}, x} * {{W{1'b0}}, y};       e.res = p[2*W-1:W]; end
      MD_DIV, MD_REM: begin
        if (y == 0) begin
          e.res = (o == MD_DIV) ? {W{1'b1}} : x; e.lat = 1;
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          e.res = (o == MD_DIV) ? x : '0; e.lat = 1;
        end else begin
          e.res = (o == MD_DIV) ? W'(sx / sy) : W'(sx % sy);
        end
      end
      default: begin
        if (y == 0) begin
          e.res = (o == MD_DIVU) ? {W{1'b1}} : x; e.lat = 1;
        end else begin
          e.res = (o == MD_DIVU) ? x / y : x % y;
        end
      end
    endcase
`ifdef MULDIV_FAST_MUL_EN
    if (o < MD_DIV) e.lat = 1;
`endif
    return e;
  endfunction

  task automatic wait_ready(input string nm);
    int n = 0;
    while (ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_timeout: ready=%b required=1", nm, ready);
    end
  endtask

  task automatic run_op(input logic [2:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input string nm);
    int   n;
    exp_t e;
    wait_ready(nm);
    sb.push_back(ref_op(o, x, y, nm));
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < W + 10);
    e = sb.pop_front();
    checks += 3;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s done_timeout: done=%b required=1", e.name, done);
    end
    if (n != e.lat) begin
      errors++;
      $display("FAIL %s latency: cycle=%0d required=%0d", e.name, n, e.lat);
    end
    if (result !== e.res) begin
      errors++;
      $display("FAIL %s result: got=%h required=%h", e.name, result, e.res);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || ready !== 1'b1 || result !== e.res) begin
      errors++;
      $display("FAIL %s after_done: done=%b ready=%b result=%h required 0/1/%h",
               e.name, done, ready, result, e.res);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || done !== 1'b0 || result !== '0) begin
      errors++;
      $display("FAIL reset_state: ready=%b done=%b result=%h required 1/0/0", ready, done, result);
    end
    // rst and a would-be immediate request on the same edge
    op = MD_DIVU; a = 32'd5; b = '0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (ready !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL rst_priority: ready=%b done=%b required 1/0", ready, done);
      end
    end
  endtask

  task automatic test_mul();
    run_op(MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_ff");
    run_op(MD_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulh_m1");
    run_op(MD_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_m1");
    run_op(MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_m1");
    run_op(MD_MULH,   32'h8000_0000, 32'h0000_0003, "mulh_neg");
    run_op(MD_MUL,    32'h1234_5678, 32'h9ABC_DEF0, "mul_mix");
  endtask

  task automatic test_div();
    run_op(MD_DIV,  32'hFFFF_FFF9, 32'd2,         "div_m7_2");
    run_op(MD_REM,  32'hFFFF_FFF9, 32'd2,         "rem_m7_2");
    run_op(MD_DIV,  32'd100,       32'hFFFF_FFF9, "div_100_m7");
    run_op(MD_REMU, 32'hFFFF_FFFF, 32'd10,        "remu_big");
    run_op(MD_DIVU, 32'd3,         32'd7,         "divu_small");
  endtask

  task automatic test_special();
    run_op(MD_DIVU, 32'd5,         32'd0,         "divu_by0");
    run_op(MD_REMU, 32'd5,         32'd0,         "remu_by0");
    run_op(MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_op(MD_REM,  32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
    run_op(MD_REM,  32'hFFFF_FFF0, 32'd0,         "rem_by0_neg");
  endtask

  task automatic test_start_in_calc();
    int   n;
    exp_t e;
    wait_ready("start_in_calc");
    sb.push_back(ref_op(MD_DIVU, 32'd1000, 32'd7, "start_in_calc"));
    op = MD_DIVU; a = 32'd1000; b = 32'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n >= 3 && n <= 8) begin
        checks++;
        if (ready !== 1'b0) begin
          errors++;
          $display("FAIL calc_ready: cycle=%0d ready=%b required=0", n, ready);
        end
        // a divide-by-zero request would finish at once if it were accepted
        op = MD_DIVU; a = 32'd5; b = '0; start = (n < 8);
      end
    end while (done !== 1'b1 && n < W + 10);
    start = 1'b0;
    e = sb.pop_front();
    checks += 2;
    if (n != e.lat) begin
      errors++;
      $display("FAIL calc_start_latency: cycle=%0d required=%0d", n, e.lat);
    end
    if (result !== e.res) begin
      errors++;
      $display("FAIL calc_start_result: got=%h required=%h", result, e.res);
    end
    @(negedge clk);
  endtask

  task automatic test_rst_mid();
    int n;
    wait_ready("rst_mid");
    sb.push_back(ref_op(MD_DIVU, 32'hFFFF_FFFF, 32'd3, "rst_mid"));
    op = MD_DIVU; a = 32'hFFFF_FFFF; b = 32'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 1; i <= 9; i++) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || done !== 1'b0 || result !== '0) begin
      errors++;
      $display("FAIL rst_mid_state: ready=%b done=%b result=%h required 1/0/0", ready, done, result);
    end
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) n++;
    end
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL rst_mid_no_done: done_pulses=%0d required=0", n);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]   o;
    logic [W-1:0] x, y;
    // start held high: accepts only in IDLE, so immediate ops pulse every other cycle
    wait_ready("hold_start");
    op = MD_DIVU; a = 32'd5; b = '0; start = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      checks++;
      if (done !== logic'(n % 2)) begin
        errors++;
        $display("FAIL hold_start: cycle=%0d done=%b required=%0d", n, done, n % 2);
      end
    end
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      o = 3'($urandom_range(0, 7));
      x = $urandom;
      y = ($urandom_range(0, 5) == 0) ? '0 : $urandom >> $urandom_range(0, 28);
      run_op(o, x, y, "b2b_rand");
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_start_in_calc();
    test_rst_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
